// File: rtl/pcm9211_pkg.sv
// Shared definitions for the PCM9211 MPIO sequencer: FSM states,
// mpio_control bit positions and default timing constants.
package pcm9211_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_HOLD,
    ST_RD_TURN,
    ST_RD_STROBE,
    ST_RD_CAPTURE
  } seq_state_t;

  localparam int MPIO_CTL_STROBE = 0;
  localparam int MPIO_CTL_DRIVE  = 1;

  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_STROBE_CYC  = 2;
  localparam int DEF_HOLD_CYC    = 4;
  localparam int DEF_CAPTURE_CYC = 2;
  localparam int DEF_POLL_DIV    = 1024;

endpackage

// File: rtl/pcm9211_poll_timer.sv
// Free-running poll divider. Counts 0..POLL_DIV-1 while enabled and
// asserts tick on the wrap cycle; disabling parks the count at 0 so the
// next enable always starts a full period.
module pcm9211_poll_timer
  import pcm9211_pkg::*;
#(
  parameter int POLL_DIV = DEF_POLL_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] count;

  // Divider count: held at zero while disabled, wraps at POLL_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/pcm9211_mpio_sequencer.sv
// Turns register-file write/read requests and periodic poll ticks into
// timed drive-enable and sample strobes for the MPIO interface stage,
// captures read results and flags changes between successive polls.
module pcm9211_mpio_sequencer
  import pcm9211_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int STROBE_CYC  = DEF_STROBE_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int CAPTURE_CYC = DEF_CAPTURE_CYC,
  parameter int POLL_DIV    = DEF_POLL_DIV
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic       poll_en,
  input  logic       irq_clr,
  output logic [7:0] mpio_control,
  output logic [7:0] mpio_wr_reg,
  input  logic [7:0] mpio_rd_reg,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       change_irq
);

  localparam logic [7:0] SETUP_LOAD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] CAPTURE_LOAD = 8'(CAPTURE_CYC - 1);

  seq_state_t state;
  logic [7:0] cnt;
  logic       wr_pend;
  logic       rd_pend;
  logic       poll_pend;
  logic       cur_poll;
  logic       strobe;
  logic       drive;
  logic       baseline_valid;
  logic [7:0] shadow;
  logic [7:0] prev_poll;
  logic       poll_tick;
  logic       cnt_done;

  pcm9211_poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_poll_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (poll_en),
    .tick   (poll_tick)
  );

  assign cnt_done = (cnt == 8'd0);
  assign busy     = (state != ST_IDLE);

  // Only the strobe and drive bits are ever used; the rest stay low.
  always_comb begin
    mpio_control                  = '0;
    mpio_control[MPIO_CTL_STROBE] = strobe;
    mpio_control[MPIO_CTL_DRIVE]  = drive;
  end

  // Sequencer FSM with request flags; request capture sits after the
  // state case so a new request in the dispatch cycle is not lost, and
  // a poll change outranks irq_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      wr_pend        <= 1'b0;
      rd_pend        <= 1'b0;
      poll_pend      <= 1'b0;
      cur_poll       <= 1'b0;
      strobe         <= 1'b0;
      drive          <= 1'b0;
      baseline_valid <= 1'b0;
      shadow         <= '0;
      prev_poll      <= '0;
      mpio_wr_reg    <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      change_irq     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (irq_clr) begin
        change_irq <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (wr_pend) begin
            state       <= ST_WR_SETUP;
            cnt         <= SETUP_LOAD;
            mpio_wr_reg <= shadow;
            drive       <= 1'b1;
            wr_pend     <= 1'b0;
          end else if (rd_pend) begin
            state    <= ST_RD_TURN;
            cnt      <= SETUP_LOAD;
            cur_poll <= 1'b0;
            rd_pend  <= 1'b0;
          end else if (poll_pend && poll_en) begin
            state     <= ST_RD_TURN;
            cnt       <= SETUP_LOAD;
            cur_poll  <= 1'b1;
            poll_pend <= 1'b0;
          end
        end

        ST_WR_SETUP: begin
          if (cnt_done) begin
            state <= ST_WR_HOLD;
            cnt   <= HOLD_LOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_WR_HOLD: begin
          if (cnt_done) begin
            state <= ST_IDLE;
            drive <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_RD_TURN: begin
          if (cnt_done) begin
            state  <= ST_RD_STROBE;
            cnt    <= STROBE_LOAD;
            strobe <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_RD_STROBE: begin
          if (cnt_done) begin
            state  <= ST_RD_CAPTURE;
            cnt    <= CAPTURE_LOAD;
            strobe <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        ST_RD_CAPTURE: begin
          if (cnt_done) begin
            state   <= ST_IDLE;
            rd_data <= mpio_rd_reg;
            if (cur_poll) begin
              if (baseline_valid && (mpio_rd_reg != prev_poll)) begin
                change_irq <= 1'b1;
              end
              prev_poll      <= mpio_rd_reg;
              baseline_valid <= 1'b1;
            end else begin
              rd_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          strobe <= 1'b0;
          drive  <= 1'b0;
        end
      endcase

      if (wr_req) begin
        wr_pend <= 1'b1;
        shadow  <= wr_data;
      end
      if (rd_req) begin
        rd_pend <= 1'b1;
      end
      if (poll_tick) begin
        poll_pend <= 1'b1;
      end
      if (!poll_en) begin
        poll_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcm9211_mpio_sequencer.sv
// Self-checking bench for pcm9211_mpio_sequencer: directed vector table,
// hand-written corner sequences and a randomized run checked every cycle
// against a transaction-timeline reference model.
module tb_pcm9211_mpio_sequencer;

  localparam int SETUP    = 4;
  localparam int STROBE   = 2;
  localparam int HOLD     = 4;
  localparam int CAPTURE  = 2;
  localparam int PDIV     = 16;
  localparam int WR_LEN   = SETUP + HOLD;
  localparam int RD_LEN   = SETUP + STROBE + CAPTURE;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_req = 1'b0;
  logic       poll_en = 1'b0;
  logic       irq_clr = 1'b0;
  logic [7:0] mpio_control;
  logic [7:0] mpio_wr_reg;
  logic [7:0] mpio_rd_reg = 8'h00;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       change_irq;

  logic [7:0] pins = 8'h00;

  int total = 0;
  int bad = 0;

  pcm9211_mpio_sequencer #(
    .SETUP_CYC  (SETUP),
    .STROBE_CYC (STROBE),
    .HOLD_CYC   (HOLD),
    .CAPTURE_CYC(CAPTURE),
    .POLL_DIV   (PDIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .rd_req      (rd_req),
    .poll_en     (poll_en),
    .irq_clr     (irq_clr),
    .mpio_control(mpio_control),
    .mpio_wr_reg (mpio_wr_reg),
    .mpio_rd_reg (mpio_rd_reg),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .change_irq  (change_irq)
  );

  always #5 clk = ~clk;

  // Interface stage: pins are latched on the rising edge of the strobe.
  always @(posedge mpio_control[0]) mpio_rd_reg = pins;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, described by its kind and
  // its age in cycles since dispatch; waveform shapes follow from the ages.
  typedef enum int {K_WR, K_RD, K_POLL} kind_t;
  bit         m_started = 0;
  bit         m_active, m_wr_pend, m_rd_pend, m_poll_pend, m_base, m_irq, m_rd_valid, m_tick;
  kind_t      m_kind;
  int         m_age, m_pcount;
  logic [7:0] m_shadow, m_wr_reg, m_rd_data, m_prev, m_latched;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_started = 1; m_active = 0; m_wr_pend = 0; m_rd_pend = 0; m_poll_pend = 0;
      m_base = 0; m_irq = 0; m_rd_valid = 0; m_kind = K_WR; m_age = 0; m_pcount = 0;
      m_shadow = 0; m_wr_reg = 0; m_rd_data = 0; m_prev = 0; m_latched = 0;
    end else begin
      m_tick = poll_en && (m_pcount == PDIV - 1);
      m_pcount = poll_en ? (m_pcount + 1) % PDIV : 0;
      m_rd_valid = 0;
      if (irq_clr) m_irq = 0;
      if (m_active) begin
        m_age++;
        if (m_kind != K_WR && m_age == SETUP) m_latched = pins;
        if (m_kind == K_WR && m_age == WR_LEN) m_active = 0;
        else if (m_kind != K_WR && m_age == RD_LEN) begin
          m_active = 0;
          m_rd_data = m_latched;
          if (m_kind == K_RD) m_rd_valid = 1;
          else begin
            if (m_base && m_latched != m_prev) m_irq = 1;
            m_prev = m_latched;
            m_base = 1;
          end
        end
      end else if (m_wr_pend) begin
        m_active = 1; m_kind = K_WR; m_age = 0; m_wr_reg = m_shadow; m_wr_pend = 0;
      end else if (m_rd_pend) begin
        m_active = 1; m_kind = K_RD; m_age = 0; m_rd_pend = 0;
      end else if (m_poll_pend && poll_en) begin
        m_active = 1; m_kind = K_POLL; m_age = 0; m_poll_pend = 0;
      end
      if (wr_req) begin m_wr_pend = 1; m_shadow = wr_data; end
      if (rd_req) m_rd_pend = 1;
      if (m_tick) m_poll_pend = 1;
      if (!poll_en) m_poll_pend = 0;
    end
  end

  // Every cycle after reset, all outputs must match the model.
  always @(negedge clk) begin
    logic [7:0] exp_ctl;
    if (m_started) begin
      exp_ctl = 8'h00;
      exp_ctl[1] = m_active && m_kind == K_WR;
      exp_ctl[0] = m_active && m_kind != K_WR && m_age >= SETUP && m_age < SETUP + STROBE;
      checkOutput("model_control", mpio_control, exp_ctl);
      checkOutput("model_wr_reg", mpio_wr_reg, m_wr_reg);
      checkOutput("model_rd_data", rd_data, m_rd_data);
      checkOutput("model_rd_valid", rd_valid, m_rd_valid);
      checkOutput("model_busy", busy, m_active);
      checkOutput("model_irq", change_irq, m_irq);
    end
  end

  typedef struct {
    bit         is_wr;
    logic [7:0] data;
    int         exp_drive;
    int         exp_strobe;
    int         exp_strobe_first;
    int         exp_busy;
    int         exp_valid_idx;
  } vec_t;

  vec_t vecs[6];

  // Issue one request and measure the resulting waveform over 14 cycles.
  task automatic applyStimulus(input vec_t v);
    int drive_n = 0, strobe_n = 0, busy_n = 0, both_n = 0, bad_wr = 0;
    int strobe_first = -1, valid_idx = -1;
    @(negedge clk);
    pins = v.data;
    if (v.is_wr) begin wr_req = 1; wr_data = v.data; end
    else rd_req = 1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      wr_req = 0; rd_req = 0;
      if (mpio_control[1]) begin
        drive_n++;
        if (mpio_wr_reg !== v.data) bad_wr++;
      end
      if (mpio_control[0]) begin
        strobe_n++;
        if (strobe_first < 0) strobe_first = k;
      end
      if (mpio_control[1] && mpio_control[0]) both_n++;
      if (busy) busy_n++;
      if (rd_valid) valid_idx = k;
    end
    checkOutput("vec_drive_cycles", drive_n, v.exp_drive);
    checkOutput("vec_strobe_cycles", strobe_n, v.exp_strobe);
    checkOutput("vec_strobe_first", strobe_first, v.exp_strobe_first);
    checkOutput("vec_busy_cycles", busy_n, v.exp_busy);
    checkOutput("vec_valid_idx", valid_idx, v.exp_valid_idx);
    checkOutput("vec_overlap", both_n, 0);
    checkOutput("vec_wr_reg_during_drive", bad_wr, 0);
    if (v.is_wr) checkOutput("vec_wr_reg_kept", mpio_wr_reg, v.data);
    else checkOutput("vec_rd_data", rd_data, v.data);
  endtask

  task automatic waitPolls(input int n);
    int seen = 0, budget = 0;
    logic prev = busy;
    while (seen < n && budget < 60 * n) begin
      @(negedge clk);
      budget++;
      if (prev && !busy) seen++;
      prev = busy;
    end
    checkOutput("poll_wait", seen, n);
  endtask

  task automatic waitStrobe();
    int budget = 0;
    while (!mpio_control[0] && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("strobe_wait", mpio_control[0], 1);
  endtask

  initial begin
    logic [7:0] wseen[4];
    int wcount, rd_cnt, writes_before, strobes, first;
    logic prev_drive;

    vecs[0] = '{1, 8'hA5, 8, 0, -1, 8, -1};
    vecs[1] = '{1, 8'h00, 8, 0, -1, 8, -1};
    vecs[2] = '{1, 8'hFF, 8, 0, -1, 8, -1};
    vecs[3] = '{0, 8'h3C, 0, 2, 6, 8, 10};
    vecs[4] = '{0, 8'hC3, 0, 2, 6, 8, 10};
    vecs[5] = '{0, 8'h00, 0, 2, 6, 8, 10};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_control", mpio_control, 8'h00);
    checkOutput("reset_wr_reg", mpio_wr_reg, 8'h00);
    checkOutput("reset_rd_data", rd_data, 8'h00);
    checkOutput("reset_rd_valid", rd_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_irq", change_irq, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] poll change interrupt");
    pins = 8'h11;
    poll_en = 1;
    waitPolls(1);
    checkOutput("poll1_irq", change_irq, 0);
    waitPolls(1);
    checkOutput("poll2_irq", change_irq, 0);
    checkOutput("poll2_rd_data", rd_data, 8'h11);
    pins = 8'h12;
    waitPolls(1);
    checkOutput("poll3_irq", change_irq, 1);
    checkOutput("poll3_rd_data", rd_data, 8'h12);
    irq_clr = 1;
    pins = 8'h13;
    @(negedge clk);
    irq_clr = 0;
    checkOutput("irq_cleared", change_irq, 0);
    waitStrobe();
    repeat (3) @(negedge clk);
    checkOutput("irq_before_clash", change_irq, 0);
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
    checkOutput("irq_set_wins", change_irq, 1);
    checkOutput("poll4_rd_data", rd_data, 8'h13);
    poll_en = 0;
    irq_clr = 1;
    @(negedge clk);
    irq_clr = 0;
    repeat (12) @(negedge clk);

    $display("[TB] priority and last-write-wins");
    wcount = 0; rd_cnt = 0; writes_before = -1; prev_drive = 0;
    for (int i = 0; i < 4; i++) wseen[i] = 8'hEE;
    wr_data = 8'h00; wr_req = 1; rd_req = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      wr_req = 0; rd_req = 0;
      if (k == 4) begin wr_req = 1; wr_data = 8'h5A; end
      if (mpio_control[1] && !prev_drive) begin
        if (wcount < 4) wseen[wcount] = mpio_wr_reg;
        wcount++;
      end
      prev_drive = mpio_control[1];
      if (rd_valid) begin rd_cnt++; writes_before = wcount; end
    end
    checkOutput("prio_write_count", wcount, 2);
    checkOutput("prio_write0", wseen[0], 8'h00);
    checkOutput("prio_write1", wseen[1], 8'h5A);
    checkOutput("prio_read_count", rd_cnt, 1);
    checkOutput("prio_read_last", writes_before, 2);

    $display("[TB] reset during strobe");
    pins = 8'h99;
    rd_req = 1;
    @(negedge clk);
    rd_req = 0;
    waitStrobe();
    reset_n = 0;
    @(negedge clk);
    checkOutput("midrst_control", mpio_control, 8'h00);
    checkOutput("midrst_busy", busy, 0);
    reset_n = 1;
    rd_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (rd_valid) rd_cnt++;
    end
    checkOutput("midrst_no_valid", rd_cnt, 0);
    applyStimulus(vecs[3]);

    $display("[TB] poll_en drop with pending poll");
    poll_en = 1;
    strobes = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      wr_req = 0;
      if (k == 10) begin wr_req = 1; wr_data = 8'h77; end
      if (k == 16) checkOutput("drop_busy_at_tick", busy, 1);
      if (k == 18) poll_en = 0;
      if (mpio_control[0]) strobes++;
    end
    checkOutput("drop_no_poll", strobes, 0);
    poll_en = 1;
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mpio_control[0] && first < 0) first = k;
    end
    checkOutput("reenable_first_strobe", first, 21);
    poll_en = 0;
    repeat (12) @(negedge clk);

    $display("[TB] randomized run");
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      wr_req  = ($urandom % 12 == 0);
      wr_data = 8'($urandom);
      rd_req  = ($urandom % 12 == 0);
      irq_clr = ($urandom % 15 == 0);
      if ($urandom % 40 == 0) poll_en = ~poll_en;
      if ($urandom % 3 == 0) pins = 8'($urandom % 4);
      reset_n = ($urandom % 300 != 0);
    end
    @(negedge clk);
    wr_req = 0; rd_req = 0; irq_clr = 0; poll_en = 0; reset_n = 1;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
